// File: rtl/dbnc_pkg.sv
// Shared types and default parameters for the dual-input debouncer.
package dbnc_pkg;

    typedef enum logic [1:0] {
        LOW,
        CHK_HIGH,
        HIGH,
        CHK_LOW
    } dbnc_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: input synchroniser, stability-count FSM, registered level and edge pulses.
//   state    | meaning
//   LOW      | output 0, synchronised input agrees with it
//   CHK_HIGH | output 0, input high, counting toward a rise
//   HIGH     | output 1, synchronised input agrees with it
//   CHK_LOW  | output 1, input low, counting toward a fall
module debounce_ch
    import dbnc_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam bit               IMMEDIATE = (STABLE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    dbnc_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Only sync_q[0] ever sees the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (s) begin
                    if (IMMEDIATE) begin
                        state_d = HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = CHK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s) begin
                    if (IMMEDIATE) begin
                        state_d = LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = CHK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/dual_input_debouncer.sv
// Two independent debounce channels feeding the a/b inputs of the downstream AND stage.
module dual_input_debouncer
    import dbnc_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    debounce_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch_a (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (a_raw),
        .level(a),
        .rise (a_rise),
        .fall (a_fall)
    );

    debounce_ch #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch_b (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (b_raw),
        .level(b),
        .rise (b_rise),
        .fall (b_fall)
    );

endmodule

// File: doc/dual_input_debouncer.md
Name: dual_input_debouncer

Overview:
- Upstream conditioning stage for the two-input AND-gate block.
- Takes two asynchronous, possibly bouncing raw inputs and synchronises each to clk.
- Debounces each input with a stability counter, then drives clean a/b levels plus single-cycle edge pulses.
- Outputs connect directly to the a/b inputs of the downstream combinational stage.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input; legal range 2..4.
- STABLE_CYCLES, 4, consecutive cycles a synchronised value must differ from the current output before the output flips; legal range 1..255.
- CNT_W, $clog2(STABLE_CYCLES+1), counter width; derived, not to be overridden.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- a_raw  input  1  raw asynchronous input A.
- b_raw  input  1  raw asynchronous input B.
- a  output  1  debounced level A.
- b  output  1  debounced level B.
- a_rise  output  1  one-cycle pulse when a goes 0->1.
- a_fall  output  1  one-cycle pulse when a goes 1->0.
- b_rise  output  1  one-cycle pulse when b goes 0->1.
- b_fall  output  1  one-cycle pulse when b goes 1->0.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous and active-low: rst_n low immediately clears all state; release is sampled on clk.
- Reset values: all synchroniser flops 0, counters 0, FSM in LOW, a=b=0, all pulse outputs 0.
- Channel independence: A and B are independent, identical channels with no cross-coupling.
- Synchroniser: SYNC_STAGES flop chain per channel; s = last stage.
- Per-channel FSM:
  - LOW (out=0): if s=1, cnt<=1 and go to CHK_HIGH; if STABLE_CYCLES=1, go directly to HIGH and pulse rise.
  - CHK_HIGH (out=0):
    - if s=0, cnt<=0 and return to LOW (glitch rejected, no pulse);
    - else if cnt==STABLE_CYCLES-1, go to HIGH, out<=1, rise<=1 for one cycle, cnt<=0;
    - else cnt<=cnt+1.
  - HIGH (out=1): mirror of LOW, watching s=0, entering CHK_LOW.
  - CHK_LOW (out=1): mirror of CHK_HIGH; on completion, out<=0 and fall<=1.
- Output timing:
  - All outputs are registered; there are no combinational paths from raw inputs.
  - Pulses last exactly one cycle, coincident with the first cycle of the new level.
- Latency: a raw transition held steady that is first captured at edge k changes the output at edge k+SYNC_STAGES+STABLE_CYCLES-1. With defaults, that is the 6th rising edge.
- Glitch rejection: any raw pulse whose synchronised width is shorter than STABLE_CYCLES cycles produces no output change and no pulse. The counter restarts from 0 on every reversion.
- Counter bounds: the counter never exceeds STABLE_CYCLES-1 and never wraps.
- Simultaneous events: A and B may flip on the same edge, and both pulses may assert in the same cycle.
- Reset mid-operation: rst_n asserted during CHK_* aborts the count. Outputs go to 0 immediately with no fall pulse, even if the output was 1.
- Metastability: only the first synchroniser flop may see asynchronous input; no other logic samples a_raw/b_raw.

Decomposition:
- Package dbnc_pkg:
  - typedef enum logic [1:0] {LOW, CHK_HIGH, HIGH, CHK_LOW} dbnc_state_t;
  - default-parameter localparams.
- Sub-module debounce_ch: one synchroniser, FSM and counter, with outputs level/rise/fall, parameterised by SYNC_STAGES/STABLE_CYCLES.
- dual_input_debouncer instantiates debounce_ch twice, using named port connections.

Test Plan:
- Reset: hold rst_n=0 with a_raw=b_raw=1 for 5 cycles -> a=b=0, all pulses 0; after release, a rises at the 6th edge with one a_rise pulse.
- Clean step (defaults): a_raw 0->1 captured at edge 10 -> a=1 and a_rise=1 at edge 15 only; b unchanged and b pulses 0.
- Glitch: a_raw high for 3 cycles, then low -> a stays 0 and no a_rise; repeat with 4 cycles -> a=1 after latency.
- Bounce then settle: b_raw toggles 1,0,1,0,1 on successive cycles, then holds 1 -> exactly one b_rise, 6 edges after the final 0->1.
- Simultaneous: a_raw and b_raw both 1->0 on the same cycle from a=b=1 -> a_fall and b_fall assert on the same edge, and the downstream AND output drops to 0 on that edge.
- Mid-count reset: rst_n pulsed low while a is in CHK_LOW with a=1 -> a=0 asynchronously, no a_fall; after release with a_raw=1, a returns to 1 after 6 edges.
